frame_scheduler: RTL and testbench

Sequences periodic transmission of the 16 status inputs over the UART transmit path. On each rising edge of the 0.25 s tick it snapshots `in[16:1]` and emits a fixed 5-byte frame (header, sequence number, two data bytes, checksum) to the UART transmitter through a valid/ready handshake. It sits between the channel inputs and the UART TX byte interface, and replaces per-bit time-multiplexed output with framed bytes.

---
 rtl/frame_scheduler.sv | 124 ++++++++++++
 tb/tb_frame_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Snapshots the 16 channel status bits on every rising edge of the 0.25 s
// tick and sends them to the UART TX as a 5-byte frame:
// header, sequence number, data low, data high, XOR checksum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a tick rising edge; tx_valid low
// SEND    | presenting byte[idx] with tx_valid high until tx_ready
// DONE    | one cycle after the checksum is taken; pulses frame_done
module frame_scheduler #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [16:1] in,
  input  logic        time_025,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [7:0]  seq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic        q1;
  logic        q2;
  logic        q3;
  logic        trig;
  logic [16:1] snap;
  logic [2:0]  idx;
  logic [7:0]  checksum;
  logic [7:0]  next_byte;

  // Bring the asynchronous tick into clk_in and keep one stage of history
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= time_025;
      q2 <= q1;
      q3 <= q2;
    end
  end

  // Rising edges of the tick only; a held-high tick fires once
  assign trig = q2 & ~q3;

  // Checksum covers the frozen snapshot and the current sequence number,
  // so input activity during a frame cannot disturb it
  assign checksum = HEADER ^ seq ^ snap[8:1] ^ snap[16:9];

  // Byte that follows the one currently on tx_data, loaded when it is taken
  always_comb begin
    next_byte = 8'h00;
    case (idx)
      3'd0:    next_byte = seq;
      3'd1:    next_byte = snap[8:1];
      3'd2:    next_byte = snap[16:9];
      3'd3:    next_byte = checksum;
      default: next_byte = 8'h00;
    endcase
  end

  // Frame sequencer: tx_data is registered and only moves on acceptance
  // or on SEND entry, so it stays stable under backpressure
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      snap    <= '0;
      idx     <= 3'd0;
      tx_data <= 8'h00;
      seq     <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            snap    <= in;
            idx     <= 3'd0;
            tx_data <= HEADER;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx == 3'd4) begin
              state <= ST_DONE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= next_byte;
            end
          end
        end
        ST_DONE: begin
          seq   <= seq + 8'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A tick that lands mid-frame is dropped and flagged for one cycle
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= trig && (state != ST_IDLE);
    end
  end

  assign tx_valid   = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: a table of hand-computed frames covering
// timing, backpressure, overrun and snapshot isolation, a mid-frame reset,
// a reset released with the tick high, and a long run of random frames
// with random tx_ready checked against a per-frame byte model.
module tb_frame_scheduler;

  logic        clk_in;
  logic        reset;
  logic [16:1] in;
  logic        time_025;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [7:0]  seq;

  frame_scheduler #(.HEADER(8'hA5)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .in         (in),
    .time_025   (time_025),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .seq        (seq)
  );

  typedef logic [7:0] frame_t [5];

  typedef struct {
    logic [15:0] data;
    int          stall_at;
    int          stall_len;
    bit          tick_chk;
    bit          flip;
    int          retick;
    int          exp_ov;
    logic [39:0] exp;
  } vec_t;

  int          n_checks;
  int          n_err;
  int          fd_cnt;
  int          ov_cnt;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_seq;
  logic [7:0]  last_b1;
  vec_t        tbl[6];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Record every byte the UART side takes
  always @(posedge clk_in) begin
    if (reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  // Count single-cycle status pulses
  always @(negedge clk_in) begin
    if (frame_done) fd_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame as the UART should see it: header, sequence, data LSB first, XOR
  function automatic frame_t model_frame(input logic [7:0] s, input logic [15:0] d);
    frame_t f;
    f[0] = 8'hA5;
    f[1] = s;
    f[2] = d[7:0];
    f[3] = d[15:8];
    f[4] = 8'h00;
    for (int i = 0; i < 4; i++) f[4] = f[4] ^ f[i];
    return f;
  endfunction

  function automatic frame_t unpack40(input logic [39:0] v);
    frame_t f;
    for (int i = 0; i < 5; i++) f[i] = v[39 - 8*i -: 8];
    return f;
  endfunction

  task automatic do_frame(input logic [15:0] d, input frame_t exp, input int stall_at,
                          input int stall_len, input bit tick_chk, input bit flip,
                          input int retick, input int exp_ov, input bit rand_rdy);
    int         cyc;
    int         stalled;
    int         extra_valid;
    bit         seen_done;
    logic [7:0] held;
    rx_q.delete();
    fd_cnt = 0;
    ov_cnt = 0;
    cyc = 0;
    stalled = 0;
    seen_done = 1'b0;
    held = 8'h00;
    @(negedge clk_in);
    in = d;
    time_025 = 1'b1;
    tx_ready = 1'b1;
    while (!seen_done && cyc < 400) begin
      @(negedge clk_in);
      cyc++;
      if (tick_chk && cyc <= 3) chk("tick_to_valid", 32'(tx_valid), 32'(cyc == 3));
      if (cyc == 3) begin
        time_025 = 1'b0;
        if (flip) in = 16'hFFFF;
      end
      if (retick > 0 && cyc == retick) time_025 = 1'b1;
      if (retick > 0 && cyc == retick + 3) time_025 = 1'b0;
      if (frame_done) seen_done = 1'b1;
      if (stall_len > 0 && stalled > 0 && stalled <= stall_len) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(held));
      end
      if (stall_len > 0 && stalled == 0 && tx_valid && rx_q.size() == stall_at) begin
        held = tx_data;
        stalled = 1;
        tx_ready = 1'b0;
      end else if (stalled > 0 && stalled < stall_len) begin
        stalled++;
        tx_ready = 1'b0;
      end else begin
        if (stalled == stall_len && stalled > 0) stalled++;
        tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("frame_done_seen", 32'(seen_done), 32'd1);
    @(negedge clk_in);
    tx_ready = 1'b1;
    exp_seq = exp_seq + 8'd1;
    chk("idle_after_frame", 32'(busy), 32'd0);
    chk("seq_after_frame", 32'(seq), 32'(exp_seq));
    chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
    chk("overrun_pulses", 32'(ov_cnt), 32'(exp_ov));
    chk("byte_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) chk($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp[i]));
      else chk($sformatf("byte%0d_missing", i), 32'hDEAD, 32'(exp[i]));
    end
    last_b1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    if (retick > 0) begin
      extra_valid = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk_in);
        if (tx_valid) extra_valid++;
      end
      chk("no_second_frame", 32'(extra_valid), 32'd0);
    end
  endtask

  initial begin
    int   cyc;
    bit   reached;
    n_checks = 0;
    n_err = 0;
    fd_cnt = 0;
    ov_cnt = 0;
    exp_seq = 8'h00;
    last_b1 = 8'h00;
    in = '0;
    time_025 = 1'b0;
    tx_ready = 1'b1;
    reset = 1'b0;

    //            data      st_at len tick flip retick ov  A5 seq lo hi ck
    tbl[0] = '{16'hBEEF, 0, 0, 1'b1, 1'b0, 0, 0, 40'hA5_00_EF_BE_F4};
    tbl[1] = '{16'h1234, 2, 3, 1'b0, 1'b0, 0, 0, 40'hA5_01_34_12_82};
    tbl[2] = '{16'h0001, 0, 0, 1'b0, 1'b1, 0, 0, 40'hA5_02_01_00_A6};
    tbl[3] = '{16'h0000, 0, 0, 1'b0, 1'b0, 5, 1, 40'hA5_03_00_00_A6};
    tbl[4] = '{16'hFFFF, 4, 1, 1'b0, 1'b0, 0, 0, 40'hA5_04_FF_FF_A1};
    tbl[5] = '{16'h8001, 0, 2, 1'b0, 1'b0, 0, 0, 40'hA5_05_01_80_21};

    repeat (3) @(negedge clk_in);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("idle_no_valid", 32'(tx_valid), 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_frame(tbl[v].data, unpack40(tbl[v].exp), tbl[v].stall_at, tbl[v].stall_len,
               tbl[v].tick_chk, tbl[v].flip, tbl[v].retick, tbl[v].exp_ov, 1'b0);
    end

    // Reset asserted between edges while byte 3 is on the bus
    rx_q.delete();
    @(negedge clk_in);
    in = 16'h5A5A;
    time_025 = 1'b1;
    tx_ready = 1'b1;
    reached = 1'b0;
    cyc = 0;
    while (!reached && cyc < 40) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 3) time_025 = 1'b0;
      if (tx_valid && rx_q.size() == 3) begin
        tx_ready = 1'b0;
        reached = 1'b1;
      end
    end
    chk("midrst_reached_byte3", 32'(reached), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_seq", 32'(seq), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    tx_ready = 1'b1;
    exp_seq = 8'h00;
    do_frame(16'hC3A1, model_frame(8'h00, 16'hC3A1), 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // 257 random frames with random backpressure; covers the seq wrap
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    exp_seq = 8'h00;
    for (int i = 0; i < 257; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      do_frame(d, model_frame(exp_seq, d), 0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
      if (i == 255) chk("wrap_seq_ff", 32'(last_b1), 32'hFF);
      if (i == 256) chk("wrap_seq_00", 32'(last_b1), 32'h00);
    end

    // Tick already high when reset releases counts as a rising edge
    @(negedge clk_in);
    reset = 1'b0;
    time_025 = 1'b1;
    in = 16'h00FF;
    rx_q.delete();
    fd_cnt = 0;
    @(negedge clk_in);
    reset = 1'b1;
    tx_ready = 1'b1;
    cyc = 0;
    while (fd_cnt == 0 && cyc < 30) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 3) time_025 = 1'b0;
    end
    @(negedge clk_in);
    chk("release_high_frame", 32'(fd_cnt), 32'd1);
    chk("release_high_bytes", 32'(rx_q.size()), 32'd5);
    if (rx_q.size() > 1) chk("release_high_seq_byte", 32'(rx_q[1]), 32'h00);
    chk("release_high_seq_after", 32'(seq), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
